// File: rtl/boardtype.sv
// Board constants for the DE0-Nano GPIO header plus arm-FSM state encoding
// and default pin-stage timing constants shared by the header mux.
package boardtype;

    localparam int GPIOWidth      = 36;
    localparam int MuxGPIOIOWidth = 34;
    localparam int MuxLedWidth    = 2;
    localparam int LEDCount       = 2;

    localparam int DefFilterLen     = 4;
    localparam int DefArmDelay      = 1024;
    localparam int DefStretchCycles = 5000000;

    typedef enum logic [1:0] {
        SAFE   = 2'd0,
        ARMING = 2'd1,
        ARMED  = 2'd2,
        FAULT  = 2'd3
    } arm_state_t;

endpackage

// File: rtl/gpio_in_filter.sv
// One header input bit: 2-flop synchroniser followed by a stability filter that
// accepts a new level only after it has been seen for FilterLen cycles.
module gpio_in_filter #(
    parameter int FilterLen = 4
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic pin_i,
    output logic filt_o
);

    localparam int CW = (FilterLen > 0) ? $clog2(FilterLen + 1) : 1;

    logic sync1_q, sync2_q, filt_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pin_i;
            sync2_q <= sync1_q;
        end
    end

    generate
        if (FilterLen == 0) begin : g_bypass
            always_ff @(posedge clk_i or posedge reset_i) begin
                if (reset_i) filt_q <= 1'b0;
                else         filt_q <= sync2_q;
            end
        end else begin : g_filter
            logic [CW-1:0] cnt_q, cnt_d;
            logic          filt_d;

            // The counter only ever holds 0..FilterLen-1; the FilterLen-th
            // mismatching cycle commits the new level instead of counting.
            always_comb begin
                filt_d = filt_q;
                cnt_d  = '0;
                if (sync2_q != filt_q) begin
                    if (cnt_q == CW'(FilterLen - 1)) filt_d = sync2_q;
                    else                             cnt_d  = cnt_q + 1'b1;
                end
            end

            always_ff @(posedge clk_i or posedge reset_i) begin
                if (reset_i) begin
                    cnt_q  <= '0;
                    filt_q <= 1'b0;
                end else begin
                    cnt_q  <= cnt_d;
                    filt_q <= filt_d;
                end
            end
        end
    endgenerate

    assign filt_o = filt_q;

endmodule

// File: rtl/hm2_gpio_header_mux.sv
// HostMot2 to DE0-Nano header pin stage: armed/gated registered outputs,
// stretched LED pins, synchronised and filtered inputs.
module hm2_gpio_header_mux
    import boardtype::*;
#(
    parameter int FilterLen     = DefFilterLen,
    parameter int ArmDelay      = DefArmDelay,
    parameter int StretchCycles = DefStretchCycles
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      hm2_ready,
    input  logic                      fault,
    input  logic [MuxGPIOIOWidth-1:0] iobits_out,
    input  logic [MuxGPIOIOWidth-1:0] iobits_oe,
    output logic [MuxGPIOIOWidth-1:0] iobits_in,
    input  logic [MuxLedWidth-1:0]    leds_in,
    input  logic [GPIOWidth-1:0]      gpio_in,
    output logic [GPIOWidth-1:0]      gpio_out,
    output logic [GPIOWidth-1:0]      gpio_oe,
    output logic [1:0]                arm_state
);

    localparam int AW = $clog2(ArmDelay + 1);
    localparam int SW = $clog2(StretchCycles + 1);

    arm_state_t    state_q, state_d;
    logic [AW-1:0] arm_cnt_q, arm_cnt_d;

    always_comb begin
        state_d   = state_q;
        arm_cnt_d = arm_cnt_q;
        if (fault) begin
            state_d = FAULT;
        end else begin
            case (state_q)
                SAFE: begin
                    if (hm2_ready) begin
                        state_d   = ARMING;
                        arm_cnt_d = '0;
                    end
                end
                ARMING: begin
                    if (!hm2_ready)                          state_d   = SAFE;
                    else if (arm_cnt_q == AW'(ArmDelay - 1)) state_d   = ARMED;
                    else                                     arm_cnt_d = arm_cnt_q + 1'b1;
                end
                ARMED:   if (!hm2_ready) state_d = SAFE;
                // Leaving FAULT needs ready low too, forcing a fresh arm sequence.
                FAULT:   if (!hm2_ready) state_d = SAFE;
                default: state_d = SAFE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= SAFE;
            arm_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            arm_cnt_q <= arm_cnt_d;
        end
    end

    assign arm_state = state_q;

    logic [MuxLedWidth-1:0]         led_prev_q;
    logic [MuxLedWidth-1:0][SW-1:0] str_cnt_q, str_cnt_d;
    logic [MuxLedWidth-1:0]         led_str;

    // The falling-edge cycle itself (led_prev_q) is covered so the pin has no gap.
    always_comb begin
        str_cnt_d = str_cnt_q;
        led_str   = '0;
        for (int j = 0; j < MuxLedWidth; j++) begin
            led_str[j] = leds_in[j] | led_prev_q[j] | (str_cnt_q[j] != '0);
            if (led_prev_q[j] && !leds_in[j]) str_cnt_d[j] = SW'(StretchCycles - 1);
            else if (str_cnt_q[j] != '0)      str_cnt_d[j] = str_cnt_q[j] - 1'b1;
        end
    end

    logic [MuxLedWidth-1:0] led_pin_d;
    logic [GPIOWidth-1:0]   gpio_out_d, gpio_oe_d;
    logic [GPIOWidth-1:0]   gpio_out_q, gpio_oe_q;

    always_comb begin
        case (state_q)
            ARMING, ARMED: led_pin_d = led_str;
            FAULT:         led_pin_d = '1;
            default:       led_pin_d = '0;
        endcase
        gpio_out_d = {led_pin_d, iobits_out};
        gpio_oe_d  = {{MuxLedWidth{1'b1}}, (state_q == ARMED) ? iobits_oe : '0};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_prev_q <= '0;
            str_cnt_q  <= '0;
            gpio_out_q <= '0;
            gpio_oe_q  <= '0;
        end else begin
            led_prev_q <= leds_in;
            str_cnt_q  <= str_cnt_d;
            gpio_out_q <= gpio_out_d;
            gpio_oe_q  <= gpio_oe_d;
        end
    end

    assign gpio_out = gpio_out_q;
    assign gpio_oe  = gpio_oe_q;

    logic [GPIOWidth-1:0]   filt;
    logic [MuxLedWidth-1:0] led_filt_unused;

    for (genvar g = 0; g < GPIOWidth; g++) begin : g_in
        gpio_in_filter #(.FilterLen(FilterLen)) u_filt (
            .clk_i   (clk),
            .reset_i (reset),
            .pin_i   (gpio_in[g]),
            .filt_o  (filt[g])
        );
    end

    assign iobits_in       = filt[MuxGPIOIOWidth-1:0];
    assign led_filt_unused = filt[GPIOWidth-1:MuxGPIOIOWidth];

endmodule

// File: tb/tb_hm2_gpio_header_mux.sv
// Directed bench for hm2_gpio_header_mux with a FIFO scoreboard of expected values.
module tb_hm2_gpio_header_mux;
    import boardtype::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        hm2_ready = 1'b0;
    logic        fault = 1'b0;
    logic [33:0] iobits_out = '0;
    logic [33:0] iobits_oe = '0;
    logic [33:0] iobits_in;
    logic [1:0]  leds_in = '0;
    logic [35:0] gpio_in = '0;
    logic [35:0] gpio_out;
    logic [35:0] gpio_oe;
    logic [1:0]  arm_state;

    hm2_gpio_header_mux #(
        .FilterLen     (4),
        .ArmDelay      (16),
        .StretchCycles (10)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .hm2_ready  (hm2_ready),
        .fault      (fault),
        .iobits_out (iobits_out),
        .iobits_oe  (iobits_oe),
        .iobits_in  (iobits_in),
        .leds_in    (leds_in),
        .gpio_in    (gpio_in),
        .gpio_out   (gpio_out),
        .gpio_oe    (gpio_oe),
        .arm_state  (arm_state)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    logic [63:0] exp_q[$];

    task automatic push(input logic [63:0] v);
        exp_q.push_back(v);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs);
        logic [63:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $error("FAIL %s scoreboard empty, observed=%h", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", tag, obs, e);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int          cnt, hi0, hi1, lat;
    logic [33:0] oe_leak;

    initial begin
        // Reset state
        #12;
        push(64'h0); push(64'h0); push(64'h0); push(64'(SAFE));
        chk("rst_gpio_oe", 64'(gpio_oe));
        chk("rst_gpio_out", 64'(gpio_out));
        chk("rst_iobits_in", 64'(iobits_in));
        chk("rst_arm_state", 64'(arm_state));
        @(posedge clk); #1;
        reset = 1'b0;
        push(64'hC_0000_0000); push(64'h0);
        tick();
        chk("safe_led_oe", 64'(gpio_oe));
        chk("safe_gpio_out", 64'(gpio_out));

        // Arm sequence
        iobits_oe  = '1;
        iobits_out = 34'h2AAAAAAAA;
        hm2_ready  = 1'b1;
        push(64'(ARMING)); push(64'd16); push(64'h0); push(64'(ARMED));
        push(64'h3_FFFF_FFFF); push(64'h2_AAAA_AAAA);
        tick();
        chk("arming_entry", 64'(arm_state));
        cnt = 1;
        oe_leak = gpio_oe[33:0];
        for (int i = 0; i < 15; i++) begin
            tick();
            if (arm_state == 2'(ARMING)) cnt++;
            oe_leak |= gpio_oe[33:0];
        end
        tick();
        oe_leak |= gpio_oe[33:0];
        chk("arming_cycles", 64'(cnt));
        chk("arming_oe_leak", 64'(oe_leak));
        chk("armed_state", 64'(arm_state));
        tick();
        chk("armed_oe", 64'(gpio_oe[33:0]));
        chk("armed_out", 64'(gpio_out[33:0]));

        // Single LED pulse
        push(64'd11); push(64'd0);
        hi0 = 0; hi1 = 0;
        for (int i = 0; i < 30; i++) begin
            leds_in = (i == 0) ? 2'b01 : 2'b00;
            tick();
            if (gpio_out[34]) hi0++;
            if (gpio_out[35]) hi1++;
        end
        chk("led_single_pulse", 64'(hi0));
        chk("led1_idle", 64'(hi1));

        // Second pulse during stretch extends the high time
        push(64'd16);
        hi0 = 0;
        for (int i = 0; i < 30; i++) begin
            leds_in = (i == 0 || i == 5) ? 2'b01 : 2'b00;
            tick();
            if (gpio_out[34]) hi0++;
        end
        chk("led_retrigger", 64'(hi0));

        // Input filter: 3-cycle glitch rejected, held change after 6 cycles
        push(64'd0);
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            gpio_in[5] = (i < 3);
            tick();
            if (iobits_in[5]) cnt++;
        end
        chk("filter_glitch", 64'(cnt));
        push(64'd6); push(64'h20);
        gpio_in[5] = 1'b1;
        lat = 0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            tick();
            if (iobits_in[5]) lat = i;
        end
        chk("filter_latency", 64'(lat));
        chk("filter_value", 64'(iobits_in));

        // One-cycle fault from ARMED
        push(64'(FAULT)); push(64'h3_FFFF_FFFF); push(64'h0); push(64'h3); push(64'h3);
        push(64'(FAULT)); push(64'(SAFE)); push(64'h0);
        fault = 1'b1;
        tick();
        chk("fault_state", 64'(arm_state));
        chk("fault_oe_edge1", 64'(gpio_oe[33:0]));
        fault = 1'b0;
        tick();
        chk("fault_oe_edge2", 64'(gpio_oe[33:0]));
        chk("fault_led_pins", 64'(gpio_out[35:34]));
        chk("fault_led_oe", 64'(gpio_oe[35:34]));
        tick();
        tick();
        chk("fault_sticky", 64'(arm_state));
        hm2_ready = 1'b0;
        tick();
        chk("fault_exit", 64'(arm_state));
        tick();
        chk("safe_led_pins", 64'(gpio_out[35:34]));

        // Aborted arming
        push(64'(ARMING)); push(64'h0); push(64'(SAFE));
        hm2_ready = 1'b1;
        tick();
        chk("rearm_entry", 64'(arm_state));
        oe_leak = gpio_oe[33:0];
        for (int i = 0; i < 7; i++) begin
            tick();
            oe_leak |= gpio_oe[33:0];
        end
        hm2_ready = 1'b0;
        tick();
        oe_leak |= gpio_oe[33:0];
        tick();
        oe_leak |= gpio_oe[33:0];
        chk("abort_oe_leak", 64'(oe_leak));
        chk("abort_state", 64'(arm_state));

        // Asynchronous reset while ARMED
        push(64'(ARMED)); push(64'h3_FFFF_FFFF); push(64'h0); push(64'h0); push(64'(SAFE));
        hm2_ready = 1'b1;
        for (int i = 0; i < 18; i++) tick();
        chk("prereset_state", 64'(arm_state));
        chk("prereset_oe", 64'(gpio_oe[33:0]));
        #2 reset = 1'b1;
        #1;
        chk("async_rst_oe", 64'(gpio_oe));
        chk("async_rst_iobits_in", 64'(iobits_in));
        chk("async_rst_state", 64'(arm_state));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hm2_gpio_header_mux.md
# hm2_gpio_header_mux

Board-level pin stage between the HostMot2 core and the DE0-Nano 40-pin GPIO header. It maps the 34 HostMot2 I/O bits and 2 LED outputs onto the 36 header pins. The output side is registered and gated by an arming state machine, so the header is never driven until the core is ready. The input side is synchronised and digitally filtered. LED activity is stretched so it stays visible.

## Interface
Parameters:
- GPIOWidth, 36, header pins handled (must equal MuxGPIOIOWidth + MuxLedWidth)
- MuxGPIOIOWidth, 34, HostMot2 I/O bits mapped to pins 0..33
- MuxLedWidth, 2, LED bits mapped to pins 34..35
- FilterLen, 4, consecutive stable cycles required before an input change is accepted; 0 = bypass
- ArmDelay, 1024, cycles hm2_ready must stay high before outputs are enabled
- StretchCycles, 5000000, minimum LED on-time in cycles (100 ms at ClockLow)

Ports:
- clk  in  1  single system clock (ClockLow domain)
- reset  in  1  asynchronous, active-high reset
- hm2_ready  in  1  core configured and running
- fault  in  1  force safe state (level)
- iobits_out  in  34  HostMot2 output data
- iobits_oe  in  34  HostMot2 per-bit output enable
- iobits_in  out  34  filtered header inputs to HostMot2
- leds_in  in  2  HostMot2 LED requests
- gpio_in  in  36  raw header pin values
- gpio_out  out  36  header drive data
- gpio_oe  out  36  header per-pin output enable
- arm_state  out  2  current FSM state: SAFE=0, ARMING=1, ARMED=2, FAULT=3

## Operation
- Arm FSM:
  - SAFE → ARMING when hm2_ready=1 and fault=0; arm counter cleared.
  - ARMING: counter increments each cycle. Reaching ArmDelay−1 → ARMED. hm2_ready=0 → SAFE.
  - ARMED → SAFE when hm2_ready=0.
  - Any state with fault=1 → FAULT. Fault has priority over ready.
  - FAULT is sticky. It exits to SAFE only when fault=0 and hm2_ready=0 in the same cycle, so the core must drop and re-assert ready.
- Output path, pins 0..33:
  - gpio_out[i] = iobits_out[i], registered.
  - gpio_oe[i] = iobits_oe[i] only in ARMED, else 0.
- LED pins 34..35:
  - gpio_oe always 1 once out of reset.
  - ARMED or ARMING: pin = stretched LED. It is high while leds_in[j]=1 or the stretch counter is nonzero. The counter loads StretchCycles−1 on the falling edge of leds_in[j] and decrements to 0.
  - SAFE: both pins 0.
  - FAULT: both pins 1.
- Input path, all 36 pins (only bits 0..33 go to iobits_in):
  - 2-flop synchroniser, then a per-bit filter.
  - Filter counter clears whenever sync value equals the filtered value.
  - Otherwise the counter increments. When it reaches FilterLen, filtered ← sync and the counter clears.
  - FilterLen=0: filtered ← sync every cycle.
  - Filter counter width = clog2(FilterLen+1); it must never wrap.
- Input path runs in every FSM state, including FAULT.

## Timing
- Reset values:
  - gpio_out=0, gpio_oe=0 (including LED pins), iobits_in=0.
  - Synchroniser, filter and stretch counters = 0; arm_state=SAFE.
- Output latency: 1 cycle from iobits_out/iobits_oe to gpio_out/gpio_oe.
- FSM transitions take effect on gpio_oe in the cycle after the state register updates: fault asserted at edge k → state FAULT at k+1 → gpio_oe[33:0]=0 at k+2.
- Arming: hm2_ready rising at edge k → ARMING at k+1 → ARMED at k+1+ArmDelay.
- Input latency: FilterLen+2 cycles from a stable gpio_in change to iobits_in. A change held for fewer than FilterLen filter cycles never propagates.
- Stretch boundaries:
  - leds_in re-rising during a stretch keeps the pin high; the counter reloads on the next falling edge.
  - A 1-cycle pulse on leds_in gives StretchCycles+1 high cycles on the pin (1 request cycle + StretchCycles).
- Reset mid-operation clears everything asynchronously: gpio_oe drops immediately, without a clock.

## Structure
- Use the boardtype package for GPIOWidth, MuxGPIOIOWidth, MuxLedWidth and LEDCount; do not redeclare them.
- Add to the same package:
  - arm_state_t enum (SAFE, ARMING, ARMED, FAULT);
  - default FilterLen, ArmDelay and StretchCycles constants.
- One sub-module, gpio_in_filter: synchroniser plus filter for one bit, instantiated 36 times.
- FSM, output registers and LED stretchers live in the top module.

## Test plan
- Reset, then hm2_ready=1 with ArmDelay=16, iobits_oe=all 1s, iobits_out=34'h2AAAAAAAA → gpio_oe[33:0] stays 0 for 16 cycles after ARMING, then all 1s; gpio_out[33:0]=34'h2AAAAAAAA.
- ARMED, pulse fault for 1 cycle → gpio_oe[33:0]=0 two edges later; pins 34..35=1; state stays FAULT until hm2_ready drops, then SAFE.
- FilterLen=4, glitch gpio_in[5] high for 3 cycles → iobits_in[5] stays 0; hold high for 4 cycles → iobits_in[5]=1 exactly 6 cycles after the change.
- StretchCycles=10, ARMED, 1-cycle leds_in[0] pulse → gpio_out[34] high for 11 cycles; second pulse at cycle 5 extends the high time to end 10 cycles after the second pulse falls.
- ARMING, drop hm2_ready at cycle 8 of 16 → back to SAFE; gpio_oe[33:0] never asserts.
- Assert reset while ARMED → gpio_oe=0 and iobits_in=0 asynchronously; arm_state=SAFE.
